pulpino_imem_arb: RTL and testbench

Two-port arbiter between the core-side instruction-memory port and the memory macro wrapper in the higher power domain. The core-side port is the `instr_mem_*` bundle leaving `pulpino_core`. The second port is a Wishbone classic slave from the management SoC, used to preload or inspect instruction RAM. The core always wins; Wishbone accesses use idle memory cycles. A timeout terminates starved Wishbone cycles with an error.

---
 rtl/pulpino_imem_arb.sv | 141 ++++++++++++++
 tb/tb_pulpino_imem_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpino_imem_arb.sv
// Instruction-memory port arbiter: pulpino core (always wins) versus a Wishbone
// classic slave that uses idle memory cycles, with a starvation timeout.
module pulpino_imem_arb #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WB_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_rstn_i,
    input  logic                    core_en_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned TMO_W = (WB_TIMEOUT > 0) ? $clog2(WB_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                r_state;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_wb_we;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_wb_dat;
    logic                  r_core_rd;
    logic [DATA_WIDTH-1:0] r_hold;

    logic w_core_req;
    logic w_wb_req;
    logic w_wb_issue;
    logic w_tmo_hit;
    logic w_unused;

    assign w_core_req = core_en_i & core_rstn_i;
    assign w_wb_req   = wb_cyc_i & wb_stb_i;
    assign w_wb_issue = (r_state == S_IDLE) & w_wb_req & ~w_core_req;
    assign w_tmo_hit  = (WB_TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(WB_TIMEOUT));
    assign w_unused   = ^{wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};

    // Memory-port mux: core first, then a Wishbone issue from IDLE only
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_core_req) begin
            mem_en_o    = 1'b1;
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_be_o    = core_be_i;
            mem_wdata_o = core_wdata_i;
        end else if (w_wb_issue) begin
            mem_en_o    = 1'b1;
            mem_we_o    = wb_we_i;
            mem_addr_o  = {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_be_o    = BE_W'(wb_sel_i);
            mem_wdata_o = DATA_WIDTH'(wb_dat_i);
        end
    end

    // Wishbone sequencing FSM with starvation timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_wb_we   <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_wb_dat  <= '0;
        end else begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_wb_req && w_core_req) begin
                        if (w_tmo_hit) begin
                            r_err   <= 1'b1;
                            r_state <= S_ACK;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        end
                    end else if (w_wb_req) begin
                        r_wb_we <= wb_we_i;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!r_wb_we) begin
                        r_wb_dat <= 32'(mem_rdata_i);
                    end
                    r_ack   <= 1'b1;
                    r_state <= S_ACK;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Core read-data hold so Wishbone reads never disturb the core's last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rd <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_core_rd <= w_core_req & ~core_we_i;
            if (r_core_rd) begin
                r_hold <= mem_rdata_i;
            end
        end
    end

    assign core_rdata_o = r_core_rd ? mem_rdata_i : r_hold;
    assign wb_dat_o     = r_wb_dat;
    assign wb_ack_o     = r_ack;
    assign wb_err_o     = r_err;

endmodule

// File: tb/tb_pulpino_imem_arb.sv
// Scoreboard bench for pulpino_imem_arb: a cycle-scheduled stimulus generator
// predicts every Wishbone response and the memory port; a negedge monitor checks.
module tb_pulpino_imem_arb;

    localparam int TMO = 6;

    typedef struct {
        bit          err;
        int unsigned cyc;
        logic [31:0] dat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_rstn_i = 1'b0;
    logic        core_en_i = 1'b0;
    logic [15:0] core_addr_i = '0;
    logic        core_we_i = 1'b0;
    logic [3:0]  core_be_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic [31:0] core_rdata_o;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    pulpino_imem_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WB_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .core_rstn_i(core_rstn_i), .core_en_i(core_en_i),
        .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro: read data valid the cycle after the request, noise otherwise
    logic [31:0] mem [0:16383] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= $urandom;
        end else if (mem_en_o) begin
            mem_rdata_i <= mem[mem_addr_o[15:2]];
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    // Reference state
    logic [31:0] sh [0:16383] = '{default: 32'h0};
    rsp_t        sb[$];
    bit          chk_en = 1'b0;
    bit          chk_rst = 1'b1;
    bit          exp_en = 1'b0;
    bit          exp_we = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_crd = '0;
    bit          pend_crd = 1'b0;
    logic [31:0] pend_val = '0;
    logic [31:0] last_rd = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(negedge clk) begin : mon
        rsp_t e;
        if (chk_rst) begin
            n_chk++;
            if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || mem_en_o !== 1'b0 ||
                wb_dat_o !== 32'h0 || core_rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_values cyc=%0d: ack=%b err=%b mem_en=%b wb_dat=%h core_rdata=%h, required all zero",
                         cyc, wb_ack_o, wb_err_o, mem_en_o, wb_dat_o, core_rdata_o);
            end
        end else if (chk_en) begin
            n_chk++;
            if (exp_en ? (mem_en_o !== 1'b1 || mem_we_o !== exp_we || mem_addr_o !== exp_addr ||
                          mem_be_o !== exp_be || (exp_we && mem_wdata_o !== exp_wdata))
                       : (mem_en_o !== 1'b0)) begin
                n_fail++;
                $display("FAIL mem_port cyc=%0d: en=%b we=%b addr=%h be=%h wdata=%h, required en=%b we=%b addr=%h be=%h wdata=%h",
                         cyc, mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                         exp_en, exp_we, exp_addr, exp_be, exp_wdata);
            end
            n_chk++;
            if (core_rdata_o !== exp_crd) begin
                n_fail++;
                $display("FAIL core_rdata cyc=%0d: got %h, required %h", cyc, core_rdata_o, exp_crd);
            end
            if (sb.size() != 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_rsp_missing cyc=%0d: no response, required %s at cyc %0d",
                         cyc, sb[0].err ? "err" : "ack", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_rsp_unexpected cyc=%0d: ack=%b err=%b, required none", cyc, wb_ack_o, wb_err_o);
                end else begin
                    e = sb.pop_front();
                    if (wb_ack_o !== !e.err || wb_err_o !== e.err || cyc != e.cyc || wb_dat_o !== e.dat) begin
                        n_fail++;
                        $display("FAIL wb_rsp cyc=%0d: ack=%b err=%b dat=%h, required ack=%b err=%b dat=%h at cyc %0d",
                                 cyc, wb_ack_o, wb_err_o, wb_dat_o, !e.err, e.err, e.dat, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_crd) begin
            exp_crd  = pend_val;
            pend_crd = 1'b0;
        end
    endtask

    task automatic sh_write(input logic [13:0] idx, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) sh[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic core_drive(input bit en, input bit rstn, input bit we, input logic [15:0] addr,
                              input logic [3:0] be, input logic [31:0] d);
        core_en_i = en; core_rstn_i = rstn; core_we_i = we;
        core_addr_i = addr; core_be_i = be; core_wdata_i = d;
        exp_en = en & rstn; exp_we = we; exp_addr = addr; exp_be = be; exp_wdata = d;
        if (en & rstn) begin
            if (we) sh_write(addr[15:2], be, d);
            else begin
                pend_crd = 1'b1;
                pend_val = sh[addr[15:2]];
            end
        end
    endtask

    // mode: 0 idle, 1 busy, 2 anything, 3 core held in reset, 4 any non-request
    task automatic core_rand(input int mode);
        int m;
        m = mode;
        if (m == 2) m = ($urandom_range(0, 1) == 0) ? 4 : 1;
        if (m == 4) m = ($urandom_range(0, 1) == 0) ? 0 : 3;
        case (m)
            0:       core_drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom_range(0, 127)), 4'($urandom), $urandom);
            1:       core_drive(1'b1, 1'b1, 1'($urandom), 16'($urandom_range(0, 127)), 4'($urandom), $urandom);
            default: core_drive(1'b1, 1'b0, 1'($urandom), 16'($urandom_range(0, 127)), 4'($urandom), $urandom);
        endcase
    endtask

    // One Wishbone cycle with n_stall core-busy cycles up front; fm = core mode when not stalling
    task automatic wb_xact(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int n_stall, input int fm);
        int unsigned s;
        int          n_busy;
        bit          tmo;
        rsp_t        e;
        tmo    = (n_stall > TMO);
        n_busy = tmo ? TMO + 1 : n_stall;
        step();
        s = cyc;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
        for (int k = 0; k < n_busy; k++) begin
            if (k > 0) step();
            core_rand(1);
        end
        if (tmo) begin
            e.err = 1'b1; e.cyc = s + TMO + 1; e.dat = last_rd;
            sb.push_back(e);
            step();
            core_rand(fm);
        end else begin
            if (n_busy > 0) step();
            core_rand((fm == 2) ? 4 : fm);
            exp_en = 1'b1; exp_we = we; exp_addr = {adr[15:2], 2'b00}; exp_be = sel; exp_wdata = dat;
            if (we) sh_write(adr[15:2], sel, dat);
            else last_rd = sh[adr[15:2]];
            e.err = 1'b0; e.cyc = s + n_busy + 2; e.dat = last_rd;
            sb.push_back(e);
            step();
            core_rand(fm);
            step();
            core_rand(fm);
        end
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        core_rand(fm);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; chk_rst = 1'b0; exp_en = 1'b0; chk_en = 1'b1;

        wb_xact(1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 0, 0);
        wb_xact(1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, 0);
        wb_xact(1'b0, 32'h0000_0040, 4'hF, 32'h0, 5, 0);
        wb_xact(1'b0, 32'h0000_0040, 4'hF, 32'h0, TMO + 1, 2);

        wb_xact(1'b1, 32'h0000_0080, 4'hF, 32'h1111_1111, 0, 0);
        wb_xact(1'b1, 32'h0000_00C0, 4'hF, 32'h2222_2222, 0, 0);
        step();
        core_drive(1'b1, 1'b1, 1'b0, 16'h0080, 4'hF, 32'h0);
        wb_xact(1'b0, 32'h0000_00C3, 4'hF, 32'h0, 0, 0);

        wb_xact(1'b1, 32'hABCD_0044, 4'h5, 32'hCAFE_F00D, 0, 3);
        wb_xact(1'b0, 32'h0000_0044, 4'hF, 32'h0, 0, 3);

        // Reset during WAIT: no response, all outputs back to zero
        step();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0040; wb_sel_i = 4'hF;
        core_rand(0);
        exp_en = 1'b1; exp_we = 1'b0; exp_addr = 16'h0040; exp_be = 4'hF;
        step();
        core_rand(0);
        #2;
        chk_en = 1'b0; chk_rst = 1'b1; rst_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; core_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; chk_rst = 1'b0;
        sb.delete();
        exp_crd = '0; pend_crd = 1'b0; last_rd = '0; exp_en = 1'b0;
        chk_en = 1'b1;
        wb_xact(1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int n;
            int fm;
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2) : $urandom_range(0, 2);
            fm = ($urandom_range(0, 7) == 0) ? 3 : 2;
            wb_xact(1'($urandom), {16'($urandom), 16'($urandom_range(0, 127))}, 4'($urandom), $urandom, n, fm);
        end

        for (int i = 0; i < 6; i++) begin
            step();
            core_rand(0);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
